// File: rtl/dnn_fix_pkg.sv
// dnn_fix_pkg: shared types and saturation helpers for the fixed-point FC layer
package dnn_fix_pkg;
   typedef enum logic [1:0] {MODE_SIG = 2'd0, MODE_LIN = 2'd1, MODE_RELU = 2'd2} mode_t;
   typedef enum logic [3:0] {
      S_IDLE, S_RD_A, S_RD_W, S_MAC, S_RD_B, S_ADD_B, S_RD_LUT, S_WR, S_DONE
   } state_t;
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value, input int width);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return value > hi ? hi : value < lo ? lo : value;
   endfunction
   // two's complement to offset binary: keep width bits, flip the sign bit
   function automatic logic [63:0] lut_index(input logic signed [63:0] value, input int width);
      logic [63:0] m;
      m = (64'd1 << width) - 64'd1;
      return (value & m) ^ (64'd1 << (width - 1));
   endfunction
endpackage

// File: rtl/dnn_mac_fix.sv
// dnn_mac_fix: signed multiply-accumulate with bias add and fixed-point post-scale
module dnn_mac_fix import dnn_fix_pkg::*; #(
   parameter int DATA_WIDTH = 11,
   parameter int FRAC_BITS = 9,
   parameter int ACC_WIDTH = 31,
   parameter logic signed [DATA_WIDTH-1:0] ONE_VAL = 11'b01000000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic acc_en,
   input  logic bias_en,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] d,
   output logic signed [ACC_WIDTH-1:0] s
);
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [2*DATA_WIDTH-1:0] prod;
   assign prod = (bias_en ? ONE_VAL : a) * d;
   assign s = acc >>> FRAC_BITS;
   always_ff @(posedge clk) begin
      if (rst || clr) acc <= '0;
      else if (acc_en || bias_en) acc <= acc + ACC_WIDTH'(prod);
   end
endmodule

// File: rtl/dnn_fc_layer_fix.sv
// dnn_fc_layer_fix: sequential fully-connected layer with selectable activation and argmax
module dnn_fc_layer_fix import dnn_fix_pkg::*; #(
   parameter int DATA_WIDTH = 11,
   parameter int FRAC_BITS = 9,
   parameter int N_IN = 400,
   parameter int N_OUT = 10,
   parameter int ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 16'h0000,
   parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = 16'h0191,
   parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_LUT = 16'h29be,
   parameter int WIDTH_SIG_LUT = 11,
   parameter logic signed [DATA_WIDTH-1:0] ONE_VAL = 11'b01000000000
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic reset,
   input  logic [1:0] mode,
   input  logic signed [DATA_WIDTH-1:0] mem_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic busy,
   output logic done,
   output logic signed [DATA_WIDTH-1:0] out [N_OUT],
   output logic [$clog2(N_OUT)-1:0] class_idx
);
   localparam int AW = 2*DATA_WIDTH + $clog2(N_IN+1);
   localparam int IW = $clog2(N_IN+1);
   localparam int JW = $clog2(N_OUT);
   state_t state, nxt;
   mode_t mode_r;
   logic [IW-1:0] i;
   logic [JW-1:0] j;
   logic signed [DATA_WIDTH-1:0] a_r, res;
   logic signed [AW-1:0] s;
   logic signed [63:0] s_dw, s_lut;
   logic [WIDTH_SIG_LUT-1:0] idx;
   logic [ADDR_WIDTH-1:0] row;
   logic clr_all, go, last_i, last_j;
   assign clr_all = rst || reset;
   assign go = start && (state == S_IDLE || state == S_DONE);
   assign last_i = i == IW'(N_IN-1);
   assign last_j = j == JW'(N_OUT-1);
   assign busy = state != S_IDLE && state != S_DONE;
   assign done = state == S_DONE;
   assign row = ADDR_BASE_W + ADDR_WIDTH'(j * (N_IN+1));
   assign s_dw = sat_signed(64'(s), DATA_WIDTH);
   assign s_lut = sat_signed(64'(s), WIDTH_SIG_LUT);
   assign idx = WIDTH_SIG_LUT'(lut_index(s_lut, WIDTH_SIG_LUT));
   assign res = mode_r == MODE_SIG ? mem_data : (mode_r == MODE_RELU && s_dw < 0) ? '0 : DATA_WIDTH'(s_dw);
   dnn_mac_fix #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .ACC_WIDTH(AW), .ONE_VAL(ONE_VAL)) u_mac (
      .clk(clk), .rst(clr_all),
      .clr(state == S_IDLE || state == S_DONE || state == S_WR),
      .acc_en(state == S_MAC), .bias_en(state == S_ADD_B),
      .a(a_r), .d(mem_data), .s(s)
   );
   always_ff @(posedge clk) state <= clr_all ? S_IDLE : nxt;
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE, S_DONE: nxt = go ? S_RD_A : state;
         S_RD_A: nxt = S_RD_W;
         S_RD_W: nxt = S_MAC;
         S_MAC: nxt = last_i ? S_RD_B : S_RD_A;
         S_RD_B: nxt = S_ADD_B;
         S_ADD_B: nxt = mode_r == MODE_SIG ? S_RD_LUT : S_WR;
         S_RD_LUT: nxt = S_WR;
         S_WR: nxt = last_j ? S_DONE : S_RD_A;
         default: nxt = S_IDLE;
      endcase
   end
   always_comb begin
      mem_addr = '0;
      case (state)
         S_RD_A: mem_addr = ADDR_BASE_A + ADDR_WIDTH'(i);
         S_RD_W: mem_addr = row + ADDR_WIDTH'(i);
         S_RD_B: mem_addr = row + ADDR_WIDTH'(N_IN);
         S_RD_LUT: mem_addr = ADDR_BASE_LUT + ADDR_WIDTH'(idx);
         default: mem_addr = '0;
      endcase
   end
   always_ff @(posedge clk) begin
      if (clr_all) begin
         i <= '0;
         j <= '0;
         a_r <= '0;
         mode_r <= MODE_SIG;
         class_idx <= '0;
         for (int k = 0; k < N_OUT; k++) out[k] <= '0;
      end else begin
         if (go) begin
            i <= '0;
            j <= '0;
            mode_r <= mode == 2'd3 ? MODE_LIN : mode_t'(mode);
         end
         if (state == S_RD_W) a_r <= mem_data;
         if (state == S_MAC) i <= last_i ? '0 : i + 1'b1;
         // ties keep the earlier neuron: only a strictly larger value takes over
         if (state == S_WR) begin
            out[j] <= res;
            if (j == '0 || res > out[class_idx]) class_idx <= j;
            if (!last_j) j <= j + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dnn_fc_layer_fix.sv
// tb_dnn_fc_layer_fix: scoreboard bench for the FC layer with a 1-cycle-latency memory
module tb_dnn_fc_layer_fix;
   localparam int DW = 11, NI = 2, NO = 3;
   localparam logic [15:0] BA = 16'h0000, BW = 16'h0191, BL = 16'h29be;
   logic clk = 0, rst = 1, start = 0, reset = 0;
   logic [1:0] mode = 0;
   logic signed [DW-1:0] mem_data;
   logic [15:0] mem_addr;
   logic busy, done;
   logic signed [DW-1:0] out [NO];
   logic [1:0] class_idx;
   logic signed [DW-1:0] mem [65536];
   int n_cmp = 0, n_bad = 0;
   int exp_q[$];
   int cls_q[$];
   always #5 clk = ~clk;
   always_ff @(posedge clk) mem_data <= mem[mem_addr];
   dnn_fc_layer_fix #(.N_IN(NI), .N_OUT(NO)) dut (
      .clk(clk), .rst(rst), .start(start), .reset(reset), .mode(mode),
      .mem_data(mem_data), .mem_addr(mem_addr), .busy(busy), .done(done),
      .out(out), .class_idx(class_idx)
   );
   function automatic int model(input int j, input int md);
      longint acc, s, sat;
      acc = longint'(mem[BW + j*(NI+1) + NI]) * 512;
      for (int i = 0; i < NI; i++) acc += longint'(mem[BA + i]) * longint'(mem[BW + j*(NI+1) + i]);
      s = acc >>> 9;
      sat = s > 1023 ? 1023 : s < -1024 ? -1024 : s;
      if (md == 0) return int'(mem[BL + int'(sat) + 1024]);
      if (md == 2 && sat < 0) return 0;
      return int'(sat);
   endfunction
   task automatic set_a(input int a0, input int a1);
      mem[BA] = DW'(a0);
      mem[BA + 1] = DW'(a1);
   endtask
   task automatic set_row(input int j, input int w0, input int w1, input int b);
      mem[BW + j*3] = DW'(w0);
      mem[BW + j*3 + 1] = DW'(w1);
      mem[BW + j*3 + 2] = DW'(b);
   endtask
   task automatic run_layer(input int md, input int poke, input string tag);
      int cnt, lat, v, bv, best, e;
      lat = NO*(3*NI + 2 + (md == 0 ? 2 : 1)) + 1;
      bv = 0;
      best = 0;
      for (int j = 0; j < NO; j++) begin
         v = model(j, md);
         exp_q.push_back(v);
         if (j == 0 || v > bv) begin bv = v; best = j; end
      end
      cls_q.push_back(best);
      mode = 2'(md);
      start = 1;
      @(posedge clk); #1;
      start = 0;
      cnt = 1;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s accept: busy=%b done=%b, want busy=1 done=0", tag, busy, done);
      end
      while (done !== 1'b1 && cnt < 500) begin
         start = (cnt == poke);
         @(posedge clk); #1;
         cnt++;
      end
      start = 0;
      n_cmp++;
      if (cnt !== lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, cnt, lat); end
      for (int j = 0; j < NO; j++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (int'(out[j]) !== e) begin n_bad++; $display("FAIL %s out[%0d]: got %0d want %0d", tag, j, out[j], e); end
      end
      e = cls_q.pop_front();
      n_cmp++;
      if (int'(class_idx) !== e) begin n_bad++; $display("FAIL %s class_idx: got %0d want %0d", tag, class_idx, e); end
   endtask
   task automatic test_reset();
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 0 || done !== 0 || mem_addr !== 0 || class_idx !== 0) begin
         n_bad++;
         $display("FAIL reset ctl: busy=%b done=%b addr=%h cls=%0d, want 0 0 0 0", busy, done, mem_addr, class_idx);
      end
      for (int j = 0; j < NO; j++) begin
         n_cmp++;
         if (out[j] !== 0) begin n_bad++; $display("FAIL reset out[%0d]: got %0d want 0", j, out[j]); end
      end
   endtask
   task automatic test_linear();
      set_a(256, 128);
      set_row(0, 512, 512, 0);
      set_row(1, -512, 100, 7);
      set_row(2, 3, -9, -300);
      run_layer(1, 0, "linear");
   endtask
   task automatic test_saturation();
      set_a(1023, 1023);
      set_row(0, 1023, 1023, 0);
      set_row(1, -1024, -1024, 0);
      set_row(2, 100, -50, 1);
      run_layer(1, 0, "sat_lin");
      run_layer(2, 0, "sat_relu");
      run_layer(3, 0, "mode3");
   endtask
   task automatic test_sigmoid();
      set_a(0, 0);
      set_row(0, 0, 0, 512);
      set_row(1, 5, 5, -700);
      set_row(2, 0, 0, 0);
      mem[BL + 1536] = 11'sd375;
      run_layer(0, 0, "sigmoid");
      set_a(1023, 1023);
      set_row(0, 1023, 1023, 0);
      set_row(1, -1024, -1024, 0);
      set_row(2, 7, -3, 40);
      run_layer(0, 0, "sig_sat");
   endtask
   task automatic test_argmax();
      set_a(512, 0);
      set_row(0, 100, 0, 0);
      set_row(1, 300, 0, 0);
      set_row(2, 300, 0, 0);
      run_layer(1, 0, "argmax_tie");
      set_row(0, -5, 0, 0);
      set_row(1, -7, 0, 0);
      set_row(2, -9, 0, 0);
      run_layer(1, 0, "argmax_neg");
      set_row(0, 1, 0, 0);
      set_row(1, 2, 0, 0);
      set_row(2, 3, 0, 0);
      run_layer(1, 0, "argmax_last");
   endtask
   task automatic test_busy_start();
      run_layer(1, 5, "poke5");
      run_layer(0, 20, "poke20");
   endtask
   task automatic test_soft_reset();
      set_a(256, 128);
      set_row(0, 512, 512, 0);
      set_row(1, 400, -200, 11);
      set_row(2, 3, 9, 30);
      run_layer(1, 0, "pre_abort");
      mode = 1;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (11) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1;
      reset = 0;
      n_cmp++;
      if (busy !== 0 || done !== 0 || mem_addr !== 0 || class_idx !== 0) begin
         n_bad++;
         $display("FAIL abort ctl: busy=%b done=%b addr=%h cls=%0d, want 0 0 0 0", busy, done, mem_addr, class_idx);
      end
      for (int j = 0; j < NO; j++) begin
         n_cmp++;
         if (out[j] !== 0) begin n_bad++; $display("FAIL abort out[%0d]: got %0d want 0", j, out[j]); end
      end
   endtask
   task automatic test_restart();
      run_layer(0, 0, "first");
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b1) begin n_bad++; $display("FAIL done_hold: got %b want 1", done); end
      run_layer(0, 0, "restart");
   endtask
   task automatic test_rst_hold();
      rst = 1;
      start = 1;
      mode = 1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (mem_addr !== 0 || done !== 0 || busy !== 0) begin
            n_bad++;
            $display("FAIL rst_hold[%0d]: addr=%h done=%b busy=%b, want 0 0 0", k, mem_addr, done, busy);
         end
      end
      start = 0;
      rst = 0;
   endtask
   initial begin
      for (int k = 0; k < 65536; k++) mem[k] = '0;
      for (int k = 0; k < 2048; k++) mem[BL + k] = DW'((k*5) % 2048 - 1024);
      test_reset();
      test_linear();
      test_saturation();
      test_sigmoid();
      test_argmax();
      test_busy_start();
      test_soft_reset();
      test_restart();
      test_rst_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
